// File: rtl/matmul_sequencer.sv
// Element-by-element sequencer for C = A*B: operand reads, MAC strobes, SP writes, sticky flags.
// Build option: define MATMUL_SEQ_OVF_EN to capture MAC overflow into flags_o[1].
module matmul_sequencer #(
    parameter int DIM   = 4,
    parameter int IDX_W = $clog2(DIM),
    parameter int SP_W  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [SP_W-1:0]      sp_sel_i,
    input  logic                 ovf_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rd_en_o,
    output logic [IDX_W-1:0]     a_row_o,
    output logic [IDX_W-1:0]     b_col_o,
    output logic [IDX_W-1:0]     k_o,
    output logic                 mac_clr_o,
    output logic                 mac_en_o,
    output logic                 res_we_o,
    output logic [2*IDX_W-1:0]   res_addr_o,
    output logic [SP_W-1:0]      sp_sel_o,
    output logic [2:0]           flags_o
);

    localparam int ADDR_W = 2 * IDX_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    i_n, j_n, k_n;
    logic [2:0]          flags_n;
    logic [SP_W-1:0]     sp_n;
    logic [ADDR_W-1:0]   addr_n;
    logic                ovf_hit;

`ifdef MATMUL_SEQ_OVF_EN
    assign ovf_hit = mac_en_o & ovf_i;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_i;
    assign ovf_hit    = 1'b0;
`endif

    // The index outputs double as the loop counters; they hold the values presented this cycle.
    always_comb begin
        state_n = state;
        i_n     = a_row_o;
        j_n     = b_col_o;
        k_n     = k_o;
        flags_n = flags_o;
        sp_n    = sp_sel_o;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (abort_i) begin
                        flags_n[2] = 1'b1;
                    end else begin
                        flags_n = 3'b000;
                        sp_n    = sp_sel_i;
                        i_n     = '0;
                        j_n     = '0;
                        k_n     = '0;
                        state_n = CLEAR;
                    end
                end
            end
            CLEAR: begin
                k_n     = k_o + 1'b1;
                state_n = MAC;
            end
            MAC: begin
                if (k_o == LAST) state_n = DRAIN;
                else             k_n     = k_o + 1'b1;
            end
            DRAIN: state_n = WRITE;
            WRITE: begin
                k_n = '0;
                if (b_col_o != LAST) begin
                    j_n     = b_col_o + 1'b1;
                    state_n = CLEAR;
                end else if (a_row_o != LAST) begin
                    j_n     = '0;
                    i_n     = a_row_o + 1'b1;
                    state_n = CLEAR;
                end else begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state != IDLE && abort_i) begin
            state_n    = IDLE;
            flags_n[2] = 1'b1;
        end
        if (state_n == DONE) flags_n[0] = 1'b1;
        if (ovf_hit)         flags_n[1] = 1'b1;
    end

    assign addr_n = ADDR_W'(i_n) * ADDR_W'(DIM) + ADDR_W'(j_n);

    // Outputs are registered from the next-state decode so every strobe leaves a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rd_en_o    <= 1'b0;
            mac_clr_o  <= 1'b0;
            mac_en_o   <= 1'b0;
            res_we_o   <= 1'b0;
            a_row_o    <= '0;
            b_col_o    <= '0;
            k_o        <= '0;
            res_addr_o <= '0;
            sp_sel_o   <= '0;
            flags_o    <= 3'b000;
        end else begin
            state      <= state_n;
            busy_o     <= (state_n != IDLE);
            done_o     <= (state_n == DONE);
            rd_en_o    <= (state_n == CLEAR) || (state_n == MAC);
            mac_clr_o  <= (state_n == CLEAR);
            mac_en_o   <= (state_n == MAC) || (state_n == DRAIN);
            res_we_o   <= (state_n == WRITE);
            a_row_o    <= i_n;
            b_col_o    <= j_n;
            k_o        <= k_n;
            if (state_n == WRITE) res_addr_o <= addr_n;
            sp_sel_o   <= sp_n;
            flags_o    <= flags_n;
        end
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequencer for the matrix-multiply datapath behind the APB register file. A start pulse from the control register launches it. It walks every result element (i,j) of C = A·B, drives Mat A / Mat B operand reads and the MAC clear/enable strobes, writes each result into the selected scratchpad (SP) bank, and maintains the sticky status bits mirrored into the flags register.

## Interface
- DIM, 4, matrix dimension N (N×N operands); legal range 2..16
- IDX_W, $clog2(DIM), width of the row/col/k indices
- SP_W, 2, width of the scratchpad bank select
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle pulse, control-register start bit written
- abort_i  in  1  one-cycle pulse, control-register abort bit written
- sp_sel_i  in  SP_W  target SP bank, sampled on accepted start
- ovf_i  in  1  MAC overflow indication, valid in cycles where mac_en_o=1
- busy_o  out  1  high from accepted start until DONE or abort
- done_o  out  1  one-cycle completion pulse
- rd_en_o  out  1  operand read strobe for Mat A and Mat B
- a_row_o / b_col_o / k_o  out  IDX_W  operand indices: A[a_row][k], B[k][b_col]
- mac_clr_o, mac_en_o  out  1  accumulator clear / accumulate
- res_we_o  out  1  SP write strobe
- res_addr_o  out  2*IDX_W  row*DIM+col of the element being written
- sp_sel_o  out  SP_W  latched bank select
- flags_o  out  3  [0] done sticky, [1] overflow sticky, [2] aborted sticky

## Operation
- States: IDLE, CLEAR, MAC, DRAIN, WRITE, DONE.
- Reset: state=IDLE. All strobes, busy_o, done_o, indices, res_addr_o, sp_sel_o and flags_o are 0.
- IDLE
  - start_i=1 and abort_i=0: clear flags_o, latch sp_sel_i, set i=j=0, go to CLEAR.
  - start_i=1 and abort_i=1: abort wins. Remain in IDLE and set flags_o[2].
- CLEAR
  - mac_clr_o=1, rd_en_o=1, k=0 presented.
  - Go to MAC if DIM>1 (always true for the legal range).
- MAC
  - rd_en_o=1 and mac_en_o=1; each cycle k increments and is presented.
  - Operand read latency is 1 cycle, so mac_en_o accumulates the data for k-1.
  - Once k=DIM-1 has been presented, go to DRAIN.
- DRAIN: mac_en_o=1, rd_en_o=0. Go to WRITE.
- WRITE
  - res_we_o=1, res_addr_o=i*DIM+j.
  - If j<DIM-1: j++.
  - Else if i<DIM-1: j=0, i++.
  - Else go to DONE. Otherwise go to CLEAR.
- DONE: done_o=1, set flags_o[0], busy_o=0 next cycle. Go to IDLE.
- start_i while busy_o=1: ignored, no state change.
- abort_i in any non-IDLE state:
  - Next state is IDLE, set flags_o[2], no done_o.
  - A WRITE in the abort cycle still completes; no further strobes follow.
- Overflow: each cycle with mac_en_o=1 and ovf_i=1 sets flags_o[1]. Bits are sticky until the next accepted start or reset.
- Index counters wrap only under sequencer control and never exceed DIM-1.

## Timing
- All outputs are registered and change only on the rising edge of clk_i.
- Start is accepted at edge 0. CLEAR occupies cycle 1.
- Per element: DIM+2 cycles (1 CLEAR + DIM-1 MAC + 1 DRAIN + 1 WRITE).
- done_o is high in cycle DIM²·(DIM+2)+1. For DIM=4 that is cycle 97; busy_o is high in cycles 1..97.
- A new start is accepted at the earliest on the cycle after done_o.
- rst_i has priority over every input, including mid-operation: IDLE, all outputs 0, flags cleared.

## Configuration
- MATMUL_SEQ_OVF_EN
  - Defined: overflow capture is as above.
  - Undefined: ovf_i is ignored (the port remains) and flags_o[1] is constant 0.
- All other behaviour is identical with or without the macro.

## Test plan
- Full run, DIM=4, start with sp_sel_i=2:
  - 16 res_we_o pulses with res_addr_o 0..15 in order.
  - done_o in cycle 97; flags_o=3'b001; sp_sel_o=2.
- Abort in cycle 20 (element 3, MAC state): IDLE by cycle 21, no done_o, flags_o=3'b100, exactly 3 writes observed.
- start_i pulsed again in cycle 10 of a run: ignored. Run completes unchanged, done_o still in cycle 97.
- ovf_i=1 for one mac_en_o cycle of element 5 (macro defined): flags_o=3'b011 at completion. With the macro undefined: flags_o=3'b001.
- rst_i=1 in cycle 50: all outputs 0 next cycle. A subsequent start produces a clean 97-cycle run.
- start_i and abort_i asserted together in IDLE: busy_o remains 0 and flags_o=3'b100.
